// File: rtl/des_key_schedule.sv
// DES key schedule generator.
// Produces the 16 round subkeys of a 64-bit DES key one at a time over a
// valid/ready handshake. Encryption order (K1..K16) uses left rotations of
// the C/D halves; decryption order (K16..K1) uses right rotations. This
// lets the register start from PC1(key) without precomputing the whole
// schedule.

module des_key_schedule #(
   parameter bit MODE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] key,
   output logic        ready,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_idx,
   output logic        done
);

   typedef enum logic {IDLE, EMIT} state_t;

   // FIPS 46-3 permuted choice 1 (key bit numbers, bit 1 = MSB).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // FIPS 46-3 permuted choice 2 (C/D bit numbers, bit 1 = MSB of C).
   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   state_t      state;
   state_t      next_state;
   logic [55:0] cd;
   logic [55:0] cd_load;
   logic [55:0] cd_step;
   logic [55:0] pc1_key;
   logic [27:0] c_cur;
   logic [27:0] d_cur;
   logic [27:0] c_pc1;
   logic [27:0] d_pc1;
   logic        load;
   logic        handshake;
   logic        last_round;
   logic        one_bit_shift;

   // Select the key bits named by PC1; parity bits are never referenced.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      logic [5:0]  src;
      logic [5:0]  dst;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         src = 6'(64 - PC1_TAB[i]);
         dst = 6'(55 - i);
         r[dst] = k[src];
      end
      return r;
   endfunction

   // Select the 48 subkey bits named by PC2 out of the 56-bit C/D pair.
   function automatic logic [47:0] pc2(input logic [55:0] v);
      logic [47:0] r;
      logic [5:0]  src;
      logic [5:0]  dst;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         src = 6'(56 - PC2_TAB[i]);
         dst = 6'(47 - i);
         r[dst] = v[src];
      end
      return r;
   endfunction

   assign pc1_key   = pc1(key);
   assign c_pc1     = pc1_key[55:28];
   assign d_pc1     = pc1_key[27:0];
   assign c_cur     = cd[55:28];
   assign d_cur     = cd[27:0];
   assign subkey    = pc2(cd);
   assign load      = (state == IDLE) && start;
   assign handshake = (state == EMIT) && subkey_ready;

   // The run ends on the handshake of K1 (decrypt) or K16 (encrypt).
   assign last_round = MODE ? (round_idx == 4'd0) : (round_idx == 4'd15);

   // Rounds 1, 2, 9 and 16 use a single-bit rotation. Going backwards we undo
   // the shift of the current round; going forwards we apply the next one.
   assign one_bit_shift = MODE ?
      ((round_idx == 4'd15) || (round_idx == 4'd8) || (round_idx == 4'd1)) :
      ((round_idx == 4'd0)  || (round_idx == 4'd7) || (round_idx == 4'd14));

   // Encryption starts one left rotation ahead so that K1 is presented first.
   always_comb begin
      cd_load = pc1_key;
      if (!MODE) begin
         cd_load = {c_pc1[26:0], c_pc1[27], d_pc1[26:0], d_pc1[27]};
      end
   end

   // Rotate C and D independently by one or two places in the mode direction.
   always_comb begin
      cd_step = cd;
      if (MODE) begin
         if (one_bit_shift) begin
            cd_step = {c_cur[0], c_cur[27:1], d_cur[0], d_cur[27:1]};
         end else begin
            cd_step = {c_cur[1:0], c_cur[27:2], d_cur[1:0], d_cur[27:2]};
         end
      end else begin
         if (one_bit_shift) begin
            cd_step = {c_cur[26:0], c_cur[27], d_cur[26:0], d_cur[27]};
         end else begin
            cd_step = {c_cur[25:0], c_cur[27:26], d_cur[25:0], d_cur[27:26]};
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: accept start when idle, leave after the final handshake.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = EMIT;
         EMIT: if (subkey_ready && last_round) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode for the handshake flags.
   always_comb begin
      ready        = 1'b0;
      subkey_valid = 1'b0;
      case (state)
         IDLE: ready = 1'b1;
         EMIT: subkey_valid = 1'b1;
         default: ready = 1'b1;
      endcase
   end

   // C/D register, round counter and done pulse; everything holds without a handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cd        <= '0;
         round_idx <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            cd        <= cd_load;
            round_idx <= MODE ? 4'd15 : 4'd0;
         end else if (handshake) begin
            if (last_round) begin
               done <= 1'b1;
            end else begin
               cd        <= cd_step;
               round_idx <= MODE ? (round_idx - 4'd1) : (round_idx + 4'd1);
            end
         end
      end
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Testbench for des_key_schedule: one encrypt-order and one decrypt-order
// instance, compared against a table-driven DES key schedule model.

module tb_des_key_schedule;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic             clk;
   logic             reset;
   logic [63:0]      key;
   logic [1:0]       start;
   logic [1:0]       subkeyReady;
   logic [1:0]       ready;
   logic [1:0]       subkeyValid;
   logic [1:0]       done;
   logic [1:0][47:0] subkey;
   logic [1:0][3:0]  roundIdx;

   logic [47:0] expKeys [16];
   int          checkCount;
   int          errorCount;

   // Instance 0 presents K1..K16, instance 1 presents K16..K1.
   des_key_schedule #(.MODE(1'b0)) dutEnc (
      .clk(clk), .reset(reset), .start(start[0]), .key(key),
      .ready(ready[0]), .subkey(subkey[0]), .subkey_valid(subkeyValid[0]),
      .subkey_ready(subkeyReady[0]), .round_idx(roundIdx[0]), .done(done[0])
   );

   des_key_schedule #(.MODE(1'b1)) dutDec (
      .clk(clk), .reset(reset), .start(start[1]), .key(key),
      .ready(ready[1]), .subkey(subkey[1]), .subkey_valid(subkeyValid[1]),
      .subkey_ready(subkeyReady[1]), .round_idx(roundIdx[1]), .done(done[1])
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: expKeys[r-1] = K_r, built from FIPS bit numbering and cumulative shifts.
   task automatic compute_schedule(input logic [63:0] k);
      logic       c [28];
      logic       d [28];
      logic [5:0] pos;
      int         tot;
      int         p;
      for (int n = 0; n < 28; n++) begin
         pos  = 6'(64 - PC1[n]);
         c[n] = k[pos];
         pos  = 6'(64 - PC1[n + 28]);
         d[n] = k[pos];
      end
      tot = 0;
      for (int r = 0; r < 16; r++) begin
         tot = tot + SHIFTS[r];
         for (int j = 0; j < 48; j++) begin
            p = PC2[j];
            if (p <= 28) expKeys[r][47 - j] = c[(p - 1 + tot) % 28];
            else         expKeys[r][47 - j] = d[(p - 29 + tot) % 28];
         end
      end
   endtask

   // Check 16 presented subkeys starting at the first valid cycle; returns at the done cycle.
   task automatic check_sequence(input int m, input logic [63:0] k, input bit bp,
                                 output logic [47:0] first, output logic [47:0] last);
      int          j;
      int          cyc;
      int          expIdx;
      logic [47:0] expKey;
      bit          acc;
      compute_schedule(k);
      first = '0;
      last  = '0;
      j     = 0;
      cyc   = 0;
      while (j < 16 && cyc < 400) begin
         expIdx = (m == 1) ? 15 - j : j;
         expKey = expKeys[expIdx];
         checkCount++;
         if (subkeyValid[m] !== 1'b1 || ready[m] !== 1'b0 || done[m] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL seq_flags m%0d j%0d: got valid=%b ready=%b done=%b, expected 1 0 0",
                     m, j, subkeyValid[m], ready[m], done[m]);
         end
         checkCount++;
         if (roundIdx[m] !== 4'(expIdx)) begin
            errorCount++;
            $display("[TB] FAIL seq_idx m%0d j%0d: got %0d, expected %0d", m, j, roundIdx[m], expIdx);
         end
         checkCount++;
         if (subkey[m] !== expKey) begin
            errorCount++;
            $display("[TB] FAIL seq_subkey m%0d idx%0d: got %h, expected %h", m, expIdx, subkey[m], expKey);
         end
         if (j == 0)  first = subkey[m];
         if (j == 15) last  = subkey[m];
         acc = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         subkeyReady[m] = acc;
         @(negedge clk);
         cyc++;
         if (acc) j++;
      end
      if (j < 16) begin
         errorCount++;
         $display("[TB] FAIL seq_timeout m%0d: got %0d handshakes, expected 16", m, j);
      end
      checkCount++;
      if (done[m] !== 1'b1 || ready[m] !== 1'b1 || subkeyValid[m] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL seq_done m%0d: got done=%b ready=%b valid=%b, expected 1 1 0",
                  m, done[m], ready[m], subkeyValid[m]);
      end
   endtask

   // Start one run, check it, and confirm done is a single-cycle pulse.
   task automatic run_mode(input int m, input logic [63:0] k, input bit bp,
                           output logic [47:0] first, output logic [47:0] last);
      checkCount++;
      if (ready[m] !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL run_ready m%0d: got %b, expected 1", m, ready[m]);
      end
      key            = k;
      start[m]       = 1'b1;
      subkeyReady[m] = 1'b1;
      @(negedge clk);
      start[m] = 1'b0;
      key      = {$urandom, $urandom};
      check_sequence(m, k, bp, first, last);
      @(negedge clk);
      checkCount++;
      if (done[m] !== 1'b0 || ready[m] !== 1'b1 || subkeyValid[m] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL run_after_done m%0d: got done=%b ready=%b valid=%b, expected 0 1 0",
                  m, done[m], ready[m], subkeyValid[m]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         checkCount++;
         if (ready[m] !== 1'b1 || subkeyValid[m] !== 1'b0 || done[m] !== 1'b0 ||
             subkey[m] !== 48'h0 || roundIdx[m] !== 4'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_state m%0d: got ready=%b valid=%b done=%b subkey=%h idx=%0d, expected 1 0 0 0 0",
                     m, ready[m], subkeyValid[m], done[m], subkey[m], roundIdx[m]);
         end
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_known_vector();
      logic [47:0] first;
      logic [47:0] last;
      run_mode(0, 64'h133457799BBCDFF1, 1'b0, first, last);
      checkCount++;
      if (first !== 48'h1B02EFFC7072 || last !== 48'hCB3D8B0E17F5) begin
         errorCount++;
         $display("[TB] FAIL known_enc: got first=%h last=%h, expected 1b02effc7072 cb3d8b0e17f5", first, last);
      end
      run_mode(1, 64'h133457799BBCDFF1, 1'b0, first, last);
      checkCount++;
      if (first !== 48'hCB3D8B0E17F5 || last !== 48'h1B02EFFC7072) begin
         errorCount++;
         $display("[TB] FAIL known_dec: got first=%h last=%h, expected cb3d8b0e17f5 1b02effc7072", first, last);
      end
   endtask

   task automatic test_zero_keys();
      logic [47:0] first;
      logic [47:0] last;
      run_mode(0, 64'h0000000000000000, 1'b0, first, last);
      run_mode(1, 64'h0101010101010101, 1'b0, first, last);
      checkCount++;
      if (first !== 48'h0 || last !== 48'h0) begin
         errorCount++;
         $display("[TB] FAIL parity_only_key: got first=%h last=%h, expected 0 0", first, last);
      end
   endtask

   task automatic test_random_keys();
      logic [47:0] first;
      logic [47:0] last;
      for (int i = 0; i < 3; i++) begin
         run_mode(0, {$urandom, $urandom}, 1'b0, first, last);
         run_mode(1, {$urandom, $urandom}, 1'b0, first, last);
      end
   endtask

   task automatic test_backpressure();
      logic [47:0] first;
      logic [47:0] last;
      for (int i = 0; i < 2; i++) begin
         run_mode(0, {$urandom, $urandom}, 1'b1, first, last);
         run_mode(1, {$urandom, $urandom}, 1'b1, first, last);
      end
   endtask

   task automatic test_reset_midrun();
      logic [47:0] first;
      logic [47:0] last;
      key            = {$urandom, $urandom};
      start[1]       = 1'b1;
      subkeyReady[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      checkCount++;
      if (roundIdx[1] !== 4'd7 || subkeyValid[1] !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL midrun_pos: got idx=%0d valid=%b, expected 7 1", roundIdx[1], subkeyValid[1]);
      end
      #2;
      reset = 1'b0;
      #1;
      checkCount++;
      if (ready[1] !== 1'b1 || subkeyValid[1] !== 1'b0 || done[1] !== 1'b0 ||
          subkey[1] !== 48'h0 || roundIdx[1] !== 4'd0) begin
         errorCount++;
         $display("[TB] FAIL midrun_async_reset: got ready=%b valid=%b done=%b subkey=%h idx=%0d, expected 1 0 0 0 0",
                  ready[1], subkeyValid[1], done[1], subkey[1], roundIdx[1]);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkCount++;
         if (done[1] !== 1'b0 || subkeyValid[1] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midrun_no_done: got done=%b valid=%b, expected 0 0", done[1], subkeyValid[1]);
         end
      end
      run_mode(1, {$urandom, $urandom}, 1'b0, first, last);
   endtask

   task automatic test_back_to_back();
      logic [63:0] k1;
      logic [63:0] k2;
      logic [47:0] first;
      logic [47:0] last;
      k1             = {$urandom, $urandom};
      k2             = {$urandom, $urandom};
      key            = k1;
      start[1]       = 1'b1;
      subkeyReady[1] = 1'b1;
      @(negedge clk);
      key = k2;
      check_sequence(1, k1, 1'b0, first, last);
      @(negedge clk);
      check_sequence(1, k2, 1'b0, first, last);
      start[1] = 1'b0;
      @(negedge clk);
      checkCount++;
      if (done[1] !== 1'b0 || ready[1] !== 1'b1 || subkeyValid[1] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL b2b_stop: got done=%b ready=%b valid=%b, expected 0 1 0",
                  done[1], ready[1], subkeyValid[1]);
      end
   endtask

   // Test sequence.
   initial begin
      checkCount  = 0;
      errorCount  = 0;
      reset       = 1'b0;
      key         = '0;
      start       = '0;
      subkeyReady = '0;
      @(negedge clk);
      test_reset();
      test_known_vector();
      test_zero_keys();
      test_random_keys();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameter: MODE, default 1, subkey order (1 = decryption order K16..K1 using right rotations; 0 = encryption order K1..K16 using left rotations).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a schedule run; sampled only when ready=1.
REQ-005 key  input  64  DES key with parity bits; bit 1 (FIPS numbering) = key[63]; sampled when start & ready.
REQ-006 ready  output  1  high when idle and able to accept start.
REQ-007 subkey  output  48  current round subkey, FIPS bit 1 = subkey[47].
REQ-008 subkey_valid  output  1  subkey and round_idx are valid.
REQ-009 subkey_ready  input  1  consumer accepts the subkey this cycle.
REQ-010 round_idx  output  4  DES round number of the presented subkey minus 1 (K1 = 0, K16 = 15).
REQ-011 done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-012 The FSM SHALL have two states: IDLE (ready=1, subkey_valid=0) and EMIT (ready=0, subkey_valid=1).
REQ-013 In IDLE, start=1 SHALL load the 56-bit C/D register with PC1(key) (MODE=1) or rotl1(C), rotl1(D) of PC1(key) (MODE=0), then move to EMIT.
REQ-014 Parity bits (FIPS bits 8,16,...,64) SHALL be discarded by PC1; PC1 and PC2 are the FIPS 46-3 tables.
REQ-015 subkey SHALL equal PC2(C,D) of the current register; latency from start accept (cycle T) to first subkey_valid SHALL be 1 cycle (valid at T+1).
REQ-016 A handshake SHALL occur when subkey_valid & subkey_ready; without it, subkey, round_idx and C/D SHALL hold unchanged.
REQ-017 Shift schedule per round r: 1 bit for r = 1, 2, 9, 16; otherwise 2 bits; C and D (28 bits each) rotate independently, wrapping bit 1 to bit 28 and vice versa.
REQ-018 MODE=1: round_idx starts at 15; on each handshake with round_idx=r-1 > 0, C/D rotate right by shift(r) and round_idx decrements.
REQ-019 MODE=0: round_idx starts at 0; on each handshake with round_idx=r-1 < 15, C/D rotate left by shift(r+1) and round_idx increments.
REQ-020 The handshake on the 16th subkey SHALL return to IDLE; done=1 and ready=1 in the following cycle; done SHALL be 0 at all other times.
REQ-021 With subkey_ready held high, the 16 subkeys SHALL appear on 16 consecutive cycles T+1..T+16, with done at T+17.
REQ-022 start while ready=0 SHALL be ignored; key SHALL not be re-sampled mid-run.
REQ-023 start on the same cycle done is high SHALL be accepted (back-to-back runs, one IDLE cycle between runs).

Reset
REQ-024 reset=0 SHALL asynchronously force: state IDLE, ready=1, subkey_valid=0, done=0, subkey=0, round_idx=0, C/D=0.
REQ-025 Reset asserted mid-run SHALL abort the run; no done pulse SHALL follow; first start after release SHALL begin a fresh run.

Verification
REQ-026 MODE=0, key=0x133457799BBCDFF1, subkey_ready=1 -> first subkey 0x1B02EFFC7072 (round_idx 0), 16th subkey 0xCB3D8B0E17F5 (round_idx 15), done at T+17.
REQ-027 MODE=1, same key -> first subkey 0xCB3D8B0E17F5 (round_idx 15), last 0x1B02EFFC7072 (round_idx 0), sequence equals MODE=0 sequence reversed.
REQ-028 key=0x0000000000000000 and key=0x0101010101010101 (parity only) -> all 16 subkeys 0x000000000000.
REQ-029 Backpressure: subkey_ready toggled pseudo-randomly -> each subkey held stable while unaccepted; exactly 16 handshakes, correct order, done once.
REQ-030 reset pulsed low at round_idx 7 -> outputs immediately at reset values, no done; new start then yields full correct sequence from round_idx 15 (MODE=1).
REQ-031 start held high continuously -> runs back-to-back, second run keyed from key value at its accept cycle; start during EMIT has no effect.
